// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator floor controller.
package elevator_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE_UP = 3'd1,
    MOVE_DN = 3'd2,
    DOOR    = 3'd3,
    EMERG   = 3'd4
  } state_t;

  localparam int DEF_N_FLOORS    = 4;
  localparam int DEF_MOVE_CYCLES = 8;
  localparam int DEF_DOOR_CYCLES = 4;

  // Floor index width; a two-floor car still needs one bit.
  function automatic int floor_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_lamp_decode.sv
// Per-floor lamp decoder: position one-hot, green and red lamps from state and floor.
module elevator_lamp_decode
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int FLOOR_W  = floor_w(N_FLOORS)
) (
  input  state_t              state,
  input  logic [FLOOR_W-1:0]  cur_floor,
  output logic [N_FLOORS-1:0] floor_onehot,
  output logic [N_FLOORS-1:0] verde,
  output logic [N_FLOORS-1:0] rojo
);

  // Position and lamp decode; green only while the car is stationary, nothing lit in emergency
  always_comb begin
    floor_onehot = {N_FLOORS{1'b0}};
    verde        = {N_FLOORS{1'b0}};
    for (int i = 0; i < N_FLOORS; i++) begin
      if (state != EMERG && cur_floor == FLOOR_W'(i)) begin
        floor_onehot[i] = 1'b1;
      end else begin
        floor_onehot[i] = 1'b0;
      end
    end
    if (state == IDLE || state == DOOR) begin
      verde = floor_onehot;
    end else begin
      verde = {N_FLOORS{1'b0}};
    end
    rojo = ~verde;
  end

endmodule

// File: rtl/elevator_floor_ctrl.sv
// Elevator controller: latches hall calls, serves them in SCAN order, times travel and door dwell.
module elevator_floor_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = DEF_N_FLOORS,
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
  parameter int FLOOR_W     = floor_w(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic                emerg,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic [N_FLOORS-1:0] floor_onehot,
  output logic [N_FLOORS-1:0] verde,
  output logic [N_FLOORS-1:0] rojo,
  output logic [N_FLOORS-1:0] pending,
  output logic                moving,
  output logic                dir_up,
  output logic                door_open
);

  localparam int MCW = $clog2(MOVE_CYCLES) + 1;
  localparam int DCW = $clog2(DOOR_CYCLES) + 1;
  localparam logic [MCW-1:0] MOVE_LAST = MCW'(MOVE_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LAST = DCW'(DOOR_CYCLES - 1);

  state_t              state_r, state_nxt_s;
  logic [FLOOR_W-1:0]  cur_floor_r, cur_floor_nxt_s, next_floor_s;
  logic                dir_up_r, dir_up_nxt_s;
  logic [N_FLOORS-1:0] pending_r, pending_nxt_s, req_s;
  logic [MCW-1:0]      move_cnt_r, move_cnt_nxt_s;
  logic [DCW-1:0]      door_cnt_r, door_cnt_nxt_s;
  logic                above_s, below_s, go_up_s, go_dn_s, at_limit_s;

  // Request summary relative to the car and the SCAN direction choice
  always_comb begin
    req_s   = pending_r | call_req;
    above_s = 1'b0;
    below_s = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FLOOR_W'(i) > cur_floor_r) begin
        above_s = above_s | req_s[i];
      end else if (FLOOR_W'(i) < cur_floor_r) begin
        below_s = below_s | req_s[i];
      end else begin
        above_s = above_s;
      end
    end
    go_up_s = above_s & (dir_up_r | ~below_s);
    go_dn_s = below_s & ~go_up_s;
    if (state_r == MOVE_UP) begin
      next_floor_s = cur_floor_r + FLOOR_W'(1);
      at_limit_s   = (next_floor_s == FLOOR_W'(N_FLOORS - 1));
    end else begin
      next_floor_s = cur_floor_r - FLOOR_W'(1);
      at_limit_s   = (next_floor_s == FLOOR_W'(0));
    end
  end

  // Next-state, call latch and timer logic
  always_comb begin
    state_nxt_s     = state_r;
    cur_floor_nxt_s = cur_floor_r;
    dir_up_nxt_s    = dir_up_r;
    pending_nxt_s   = pending_r | call_req;
    move_cnt_nxt_s  = move_cnt_r;
    door_cnt_nxt_s  = door_cnt_r;
    if (emerg) begin
      state_nxt_s    = EMERG;
      pending_nxt_s  = {N_FLOORS{1'b0}};
      move_cnt_nxt_s = MCW'(0);
      door_cnt_nxt_s = DCW'(0);
    end else begin
      case (state_r)
        IDLE: begin
          pending_nxt_s[cur_floor_r] = 1'b0;
          if (req_s[cur_floor_r]) begin
            state_nxt_s    = DOOR;
            door_cnt_nxt_s = DCW'(0);
          end else if (go_up_s) begin
            state_nxt_s    = MOVE_UP;
            dir_up_nxt_s   = 1'b1;
            move_cnt_nxt_s = MCW'(0);
          end else if (go_dn_s) begin
            state_nxt_s    = MOVE_DN;
            dir_up_nxt_s   = 1'b0;
            move_cnt_nxt_s = MCW'(0);
          end else begin
            state_nxt_s = IDLE;
          end
        end
        MOVE_UP, MOVE_DN: begin
          if (move_cnt_r == MOVE_LAST) begin
            cur_floor_nxt_s = next_floor_s;
            move_cnt_nxt_s  = MCW'(0);
            // Stop on arrival if the new floor is wanted; never drive past an end floor
            if (req_s[next_floor_s]) begin
              state_nxt_s                  = DOOR;
              pending_nxt_s[next_floor_s]  = 1'b0;
              door_cnt_nxt_s               = DCW'(0);
            end else if (at_limit_s) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = state_r;
            end
          end else begin
            move_cnt_nxt_s = move_cnt_r + MCW'(1);
          end
        end
        DOOR: begin
          pending_nxt_s[cur_floor_r] = 1'b0;
          if (call_req[cur_floor_r]) begin
            door_cnt_nxt_s = DCW'(0);
          end else if (door_cnt_r == DOOR_LAST) begin
            door_cnt_nxt_s = DCW'(0);
            move_cnt_nxt_s = MCW'(0);
            if (go_up_s) begin
              state_nxt_s  = MOVE_UP;
              dir_up_nxt_s = 1'b1;
            end else if (go_dn_s) begin
              state_nxt_s  = MOVE_DN;
              dir_up_nxt_s = 1'b0;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            door_cnt_nxt_s = door_cnt_r + DCW'(1);
          end
        end
        EMERG: begin
          state_nxt_s    = IDLE;
          pending_nxt_s  = {N_FLOORS{1'b0}};
          move_cnt_nxt_s = MCW'(0);
          door_cnt_nxt_s = DCW'(0);
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cur_floor_r <= FLOOR_W'(0);
      dir_up_r    <= 1'b1;
      pending_r   <= {N_FLOORS{1'b0}};
      move_cnt_r  <= MCW'(0);
      door_cnt_r  <= DCW'(0);
    end else begin
      state_r     <= state_nxt_s;
      cur_floor_r <= cur_floor_nxt_s;
      dir_up_r    <= dir_up_nxt_s;
      pending_r   <= pending_nxt_s;
      move_cnt_r  <= move_cnt_nxt_s;
      door_cnt_r  <= door_cnt_nxt_s;
    end
  end

  assign cur_floor = cur_floor_r;
  assign dir_up    = dir_up_r;
  assign pending   = pending_r;
  assign moving    = (state_r == MOVE_UP) || (state_r == MOVE_DN);
  assign door_open = (state_r == DOOR);

  elevator_lamp_decode #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_lamp (
    .state        (state_r),
    .cur_floor    (cur_floor_r),
    .floor_onehot (floor_onehot),
    .verde        (verde),
    .rojo         (rojo)
  );

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Directed, table-driven bench for elevator_floor_ctrl (4 floors, 8-cycle travel, 4-cycle dwell).
module tb_elevator_floor_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] call_req = 4'b0000;
  logic       emerg = 1'b0;
  logic [1:0] cur_floor;
  logic [3:0] floor_onehot, verde, rojo, pending;
  logic       moving, dir_up, door_open;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  elevator_floor_ctrl #(
    .N_FLOORS    (4),
    .MOVE_CYCLES (8),
    .DOOR_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .call_req     (call_req),
    .emerg        (emerg),
    .cur_floor    (cur_floor),
    .floor_onehot (floor_onehot),
    .verde        (verde),
    .rojo         (rojo),
    .pending      (pending),
    .moving       (moving),
    .dir_up       (dir_up),
    .door_open    (door_open)
  );

  // Inputs are held for n clocks, then all outputs are compared with the expected record
  typedef struct {
    logic       rst;
    logic [3:0] call;
    logic       emerg;
    int         n;
    logic [1:0] cf;
    logic       dir;
    logic       mov;
    logic       door;
    logic [3:0] pend;
    logic [3:0] verde;
    logic [3:0] rojo;
    logic [3:0] oh;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] c, input logic e, input int n,
                     input logic [1:0] cf, input logic dir, input logic mov, input logic door,
                     input logic [3:0] pend, input logic [3:0] vd, input logic [3:0] rj,
                     input logic [3:0] oh);
    vec_t v;
    v.rst = r; v.call = c; v.emerg = e; v.n = n;
    v.cf = cf; v.dir = dir; v.mov = mov; v.door = door;
    v.pend = pend; v.verde = vd; v.rojo = rj; v.oh = oh;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  logic [20:0] obs, expv;
  int first_door, door_len;

  initial begin
    //   rst  call     em  n   cf    dir   mov   door  pend     verde    rojo     oh
    // reset, then a single call to the top floor
    add(1'b1, 4'b0000, 1'b0, 2, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b1110, 4'b0001);
    add(1'b0, 4'b1000, 1'b0, 1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1111, 4'b0001);
    add(1'b0, 4'b0000, 1'b0, 7, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1111, 4'b0001);
    add(1'b0, 4'b0000, 1'b0, 1, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1111, 4'b0010);
    add(1'b0, 4'b0000, 1'b0, 8, 2'd2, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1111, 4'b0100);
    add(1'b0, 4'b0000, 1'b0, 7, 2'd2, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1111, 4'b0100);
    add(1'b0, 4'b0000, 1'b0, 1, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 4'b0111, 4'b1000);
    add(1'b0, 4'b0000, 1'b0, 3, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 4'b0111, 4'b1000);
    add(1'b0, 4'b0000, 1'b0, 1, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0111, 4'b1000);
    add(1'b0, 4'b0000, 1'b0, 5, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0111, 4'b1000);
    // en-route stop at floor 2 on the way to floor 3
    add(1'b1, 4'b0000, 1'b0, 1, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b1110, 4'b0001);
    add(1'b0, 4'b1000, 1'b0, 1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1111, 4'b0001);
    add(1'b0, 4'b0000, 1'b0, 2, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1111, 4'b0001);
    add(1'b0, 4'b0100, 1'b0, 1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b0000, 4'b1111, 4'b0001);
    add(1'b0, 4'b0000, 1'b0, 13, 2'd2, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0100, 4'b1011, 4'b0100);
    add(1'b0, 4'b0000, 1'b0, 4, 2'd2, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1111, 4'b0100);
    add(1'b0, 4'b0000, 1'b0, 8, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 4'b0111, 4'b1000);
    add(1'b0, 4'b0000, 1'b0, 4, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0111, 4'b1000);
    // reversal: at floor 2 heading up with only floor 0 pending
    add(1'b1, 4'b0000, 1'b0, 1, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b1110, 4'b0001);
    add(1'b0, 4'b0100, 1'b0, 1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b1111, 4'b0001);
    add(1'b0, 4'b0000, 1'b0, 16, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b1011, 4'b0100);
    add(1'b0, 4'b0001, 1'b0, 1, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0100, 4'b1011, 4'b0100);
    add(1'b0, 4'b0000, 1'b0, 3, 2'd2, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b1111, 4'b0100);
    add(1'b0, 4'b0000, 1'b0, 8, 2'd1, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b1111, 4'b0010);
    add(1'b0, 4'b0000, 1'b0, 8, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 4'b1110, 4'b0001);
    add(1'b0, 4'b0000, 1'b0, 4, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b1110, 4'b0001);
    // emergency during travel from floor 1 to floor 2
    add(1'b0, 4'b0100, 1'b0, 1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b1111, 4'b0001);
    add(1'b0, 4'b0000, 1'b0, 12, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b1111, 4'b0010);
    add(1'b0, 4'b0000, 1'b1, 1, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    add(1'b0, 4'b1000, 1'b1, 2, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    add(1'b0, 4'b0000, 1'b0, 1, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b1101, 4'b0010);
    add(1'b0, 4'b0000, 1'b0, 3, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b1101, 4'b0010);
    // same-floor call at floor 2 and dwell extension on re-press
    add(1'b0, 4'b0100, 1'b0, 1, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b1111, 4'b0010);
    add(1'b0, 4'b0000, 1'b0, 12, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b1011, 4'b0100);
    add(1'b0, 4'b0100, 1'b0, 1, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b1011, 4'b0100);
    add(1'b0, 4'b0000, 1'b0, 2, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b1011, 4'b0100);
    add(1'b0, 4'b0100, 1'b0, 1, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b1011, 4'b0100);
    add(1'b0, 4'b0000, 1'b0, 3, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b1011, 4'b0100);
    add(1'b0, 4'b0000, 1'b0, 1, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b1011, 4'b0100);
    // downward departure, then reset mid-travel
    add(1'b0, 4'b0001, 1'b0, 3, 2'd2, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b1111, 4'b0100);
    add(1'b1, 4'b0000, 1'b0, 1, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b1110, 4'b0001);

    @(negedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      rst      = vecs[k].rst;
      call_req = vecs[k].call;
      emerg    = vecs[k].emerg;
      repeat (vecs[k].n) @(posedge clk);
      @(negedge clk);
      obs  = {cur_floor, dir_up, moving, door_open, pending, verde, rojo, floor_onehot};
      expv = {vecs[k].cf, vecs[k].dir, vecs[k].mov, vecs[k].door, vecs[k].pend,
              vecs[k].verde, vecs[k].rojo, vecs[k].oh};
      check($sformatf("vec%0d", k), 32'(obs), 32'(expv));
    end

    // Cycle-accurate door timing for a single call 0 -> 3 (door expected in cycles t+25..t+28)
    rst = 1'b1; call_req = 4'b0000; emerg = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; call_req = 4'b1000;
    first_door = -1; door_len = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      call_req = 4'b0000;
      if (door_open) begin
        if (first_door < 0) first_door = c;
        door_len++;
      end
    end
    check("door_first_cycle", 32'(first_door), 32'd25);
    check("door_dwell_len", 32'(door_len), 32'd4);
    check("final_idle_floor", 32'({cur_floor, moving, door_open}), 32'({2'd3, 1'b0, 1'b0}));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
